// File: rtl/sr_pulse_sequencer.sv
// rtl/sr_pulse_sequencer.sv - debounced set/clear requests turned into spaced one-cycle S/R pulses
module sr_pulse_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_GAP         = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic SET_IN,
  input  logic CLR_IN,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic CONFLICT
);

  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(MIN_GAP - 1);

  typedef enum logic [1:0] {IDLE, SET_PULSE, CLR_PULSE, GAP} state_t;

  // Bit 0 of every pair is the set path, bit 1 the clear path.
  logic [1:0] raw, sync1, sync2, deb, deb_q, req_edge, eff;
  logic [1:0] pend, pend_next;
  logic [7:0] db_cnt [2];
  state_t     state, state_next;
  logic [3:0] gap_cnt, gap_next;
  logic       s_next, r_next, conflict_next, arb;

  assign raw      = {CLR_IN, SET_IN};
  assign req_edge = deb & ~deb_q;
  assign eff      = pend | req_edge;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      deb_q     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // The last GAP cycle arbitrates exactly like IDLE, so a queued request
  // is served in the first cycle after the gap.
  always_comb begin
    state_next    = state;
    gap_next      = gap_cnt;
    pend_next     = pend | req_edge;
    conflict_next = 1'b0;
    arb           = 1'b0;
    case (state)
      IDLE: arb = 1'b1;
      SET_PULSE, CLR_PULSE: begin
        state_next = GAP;
        gap_next   = '0;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          arb      = 1'b1;
          gap_next = '0;
        end else begin
          gap_next = gap_cnt + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (arb) begin
      state_next = IDLE;
      pend_next  = '0;
      case (eff)
        2'b01:   state_next    = SET_PULSE;
        2'b10:   state_next    = CLR_PULSE;
        2'b11:   conflict_next = 1'b1;
        default: state_next    = IDLE;
      endcase
    end
    s_next = (state_next == SET_PULSE);
    r_next = (state_next == CLR_PULSE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      pend     <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      BUSY     <= 1'b0;
      CONFLICT <= 1'b0;
    end else begin
      state    <= state_next;
      gap_cnt  <= gap_next;
      pend     <= pend_next;
      S        <= s_next;
      R        <= r_next;
      BUSY     <= (state_next != IDLE);
      CONFLICT <= conflict_next;
    end
  end

endmodule
